// File: rtl/tms_progmem_arbiter.sv
// Program SRAM arbiter for the wrapped TMS1x00 core: shares the single-port SRAM between
// Wishbone program load/verify and CPU instruction fetch, and holds the CPU control register.
module tms_progmem_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int MAX_WAIT = 4
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              cpu_fetch_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_data,
    output logic              cpu_data_valid,
    output logic              cpu_rst_n_o,
    output logic              cpu_mode_o,
    output logic              mem_csb,
    output logic              mem_web,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CPU_RD  = 3'd1,
        ST_CPU_CAP = 3'd2,
        ST_WB_RD   = 3'd3,
        ST_WB_CAP  = 3'd4,
        ST_WB_WR   = 3'd5,
        ST_REG     = 3'd6
    } state_t;

    state_t            state_r, state_next_s;
    logic              run_r, run_next_s;
    logic              mode_r, mode_next_s;
    logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_next_s;
    logic [7:0]        forced_cnt_r, forced_cnt_next_s;
    logic              ack_r, ack_next_s;
    logic [31:0]       wb_dat_r, wb_dat_next_s;
    logic [7:0]        cpu_data_r, cpu_data_next_s;
    logic              cpu_valid_r, cpu_valid_next_s;
    logic              mem_csb_r, mem_csb_next_s;
    logic              mem_web_r, mem_web_next_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_next_s;
    logic [7:0]        mem_din_r, mem_din_next_s;

    logic              wb_req_s;
    logic              cpu_req_s;
    logic              wb_grant_s;
    logic              cpu_grant_s;
    logic [ADDR_W-1:0] mem_idx_s;
    logic              unused_s;

    assign wb_req_s    = wbs_cyc_i & wbs_stb_i;
    assign cpu_req_s   = cpu_fetch_req & run_r;
    // Wishbone is granted when uncontested, or when it has already lost MAX_WAIT times
    assign wb_grant_s  = wb_req_s & (~cpu_req_s | (wait_cnt_r == WAIT_MAX));
    assign cpu_grant_s = cpu_req_s & ~wb_grant_s;
    assign mem_idx_s   = wbs_adr_i[ADDR_W+1:2];
    assign unused_s    = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[31:17],
                           wbs_adr_i[15:ADDR_W+2], wbs_adr_i[1:0]};

    // Next-state, arbitration and next values of all registered outputs
    always_comb begin
        state_next_s      = state_r;
        run_next_s        = run_r;
        mode_next_s       = mode_r;
        wait_cnt_next_s   = wait_cnt_r;
        forced_cnt_next_s = forced_cnt_r;
        ack_next_s        = 1'b0;
        wb_dat_next_s     = wb_dat_r;
        cpu_data_next_s   = cpu_data_r;
        cpu_valid_next_s  = 1'b0;
        mem_csb_next_s    = 1'b1;
        mem_web_next_s    = 1'b1;
        mem_addr_next_s   = mem_addr_r;
        mem_din_next_s    = mem_din_r;
        case (state_r)
            ST_IDLE: begin
                if (wb_grant_s) begin
                    wait_cnt_next_s = {WAIT_W{1'b0}};
                    if (cpu_req_s && (forced_cnt_r != 8'hFF)) begin
                        forced_cnt_next_s = forced_cnt_r + 8'd1;
                    end else begin
                        forced_cnt_next_s = forced_cnt_r;
                    end
                    if (wbs_adr_i[16]) begin
                        mem_addr_next_s = mem_idx_s;
                        if (wbs_we_i) begin
                            state_next_s   = ST_WB_WR;
                            mem_din_next_s = wbs_dat_i[7:0];
                            // a write without byte lane 0 still acks but leaves the SRAM idle
                            if (wbs_sel_i[0]) begin
                                mem_csb_next_s = 1'b0;
                                mem_web_next_s = 1'b0;
                            end else begin
                                mem_csb_next_s = 1'b1;
                            end
                        end else begin
                            state_next_s   = ST_WB_RD;
                            mem_csb_next_s = 1'b0;
                        end
                    end else begin
                        state_next_s = ST_REG;
                    end
                end else if (cpu_grant_s) begin
                    state_next_s    = ST_CPU_RD;
                    mem_csb_next_s  = 1'b0;
                    mem_addr_next_s = cpu_addr;
                    if (wb_req_s && (wait_cnt_r != WAIT_MAX)) begin
                        wait_cnt_next_s = wait_cnt_r + WAIT_W'(1'b1);
                    end else begin
                        wait_cnt_next_s = wait_cnt_r;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CPU_RD: begin
                state_next_s = ST_CPU_CAP;
            end
            ST_CPU_CAP: begin
                state_next_s     = ST_IDLE;
                cpu_data_next_s  = mem_dout;
                cpu_valid_next_s = 1'b1;
            end
            ST_WB_RD: begin
                state_next_s = ST_WB_CAP;
            end
            ST_WB_CAP: begin
                state_next_s  = ST_IDLE;
                wb_dat_next_s = {24'h00_0000, mem_dout};
                ack_next_s    = 1'b1;
            end
            ST_WB_WR: begin
                state_next_s  = ST_IDLE;
                wb_dat_next_s = 32'h0000_0000;
                ack_next_s    = 1'b1;
            end
            ST_REG: begin
                state_next_s = ST_IDLE;
                ack_next_s   = 1'b1;
                if (wbs_we_i) begin
                    wb_dat_next_s = 32'h0000_0000;
                    if (wbs_adr_i[3:2] == 2'd0) begin
                        run_next_s        = wbs_dat_i[0];
                        mode_next_s       = wbs_dat_i[1];
                        forced_cnt_next_s = 8'h00;
                    end else begin
                        run_next_s = run_r;
                    end
                end else begin
                    case (wbs_adr_i[3:2])
                        2'd0:    wb_dat_next_s = {30'h0000_0000, mode_r, run_r};
                        2'd1:    wb_dat_next_s = {16'h0000, forced_cnt_r, 7'h00, run_r};
                        default: wb_dat_next_s = 32'h0000_0000;
                    endcase
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transfer
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            run_r        <= 1'b0;
            mode_r       <= 1'b0;
            wait_cnt_r   <= {WAIT_W{1'b0}};
            forced_cnt_r <= 8'h00;
            ack_r        <= 1'b0;
            wb_dat_r     <= 32'h0000_0000;
            cpu_data_r   <= 8'h00;
            cpu_valid_r  <= 1'b0;
            mem_csb_r    <= 1'b1;
            mem_web_r    <= 1'b1;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_din_r    <= 8'h00;
        end else begin
            state_r      <= state_next_s;
            run_r        <= run_next_s;
            mode_r       <= mode_next_s;
            wait_cnt_r   <= wait_cnt_next_s;
            forced_cnt_r <= forced_cnt_next_s;
            ack_r        <= ack_next_s;
            wb_dat_r     <= wb_dat_next_s;
            cpu_data_r   <= cpu_data_next_s;
            cpu_valid_r  <= cpu_valid_next_s;
            mem_csb_r    <= mem_csb_next_s;
            mem_web_r    <= mem_web_next_s;
            mem_addr_r   <= mem_addr_next_s;
            mem_din_r    <= mem_din_next_s;
        end
    end

    assign wbs_ack_o      = ack_r;
    assign wbs_dat_o      = wb_dat_r;
    assign cpu_data       = cpu_data_r;
    assign cpu_data_valid = cpu_valid_r;
    assign cpu_rst_n_o    = run_r;
    assign cpu_mode_o     = mode_r;
    assign mem_csb        = mem_csb_r;
    assign mem_web        = mem_web_r;
    assign mem_addr       = mem_addr_r;
    assign mem_din        = mem_din_r;

endmodule
